// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Funct3 legality and natural-alignment checks live here.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_t;

    function automatic logic is_legal(input logic       write,
                                      input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!write) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = !off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory signals of the load/store unit.
// master: the unit itself; slave: the core/memory environment.
interface load_store_unit_if;

    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [2:0]  Req_Funct3;
    logic [31:0] Req_Address;
    logic [31:0] Req_Write_Data;
    logic        Resp_Valid;
    logic [31:0] Resp_Data;
    logic        Resp_Error;
    logic        Mem_Req;
    logic        Mem_Write;
    logic [31:0] Mem_Address;
    logic [3:0]  Mem_Byte_En;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Ack;
    logic [31:0] Mem_Read_Data;

    modport master (
        input  Req_Valid, Req_Write, Req_Funct3,
        input  Req_Address, Req_Write_Data,
        output Req_Ready, Resp_Valid, Resp_Data, Resp_Error,
        output Mem_Req, Mem_Write, Mem_Address,
        output Mem_Byte_En, Mem_Write_Data,
        input  Mem_Ack, Mem_Read_Data
    );

    modport slave (
        output Req_Valid, Req_Write, Req_Funct3,
        output Req_Address, Req_Write_Data,
        input  Req_Ready, Resp_Valid, Resp_Data, Resp_Error,
        input  Mem_Req, Mem_Write, Mem_Address,
        input  Mem_Byte_En, Mem_Write_Data,
        output Mem_Ack, Mem_Read_Data
    );

endinterface

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store replication, load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [31:0] word;

    assign word = read_data >> {offset, 3'b000};

    always_comb begin
        byte_en    = 4'b1111;
        write_data = store_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << offset;
                write_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << offset;
                write_data = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = word;
        unique case (1'b1)
            (funct3 == F3_B):  load_data = {{24{word[7]}}, word[7:0]};
            (funct3 == F3_H):  load_data = {{16{word[15]}}, word[15:0]};
            (funct3 == F3_BU): load_data = {24'h0, word[7:0]};
            (funct3 == F3_HU): load_data = {16'h0, word[15:0]};
            default:           load_data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access, drives the word-addressed
// memory with a timeout, and returns a single-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Rst_n,
    load_store_unit_if.master bus
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic        ready_q, ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        xfer;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic [3:0]  be_gen;
    logic [31:0] wdata_gen;
    logic [31:0] load_ext;

    assign xfer = bus.Req_Valid && ready_q;

    // Live request fields at accept, latched ones during the access.
    assign f3_sel  = (state_q == IDLE) ? bus.Req_Funct3 : f3_q;
    assign off_sel = (state_q == IDLE) ? bus.Req_Address[1:0] : off_q;

    lsu_align u_align (
        .funct3     (f3_sel),
        .offset     (off_sel),
        .store_data (bus.Req_Write_Data),
        .read_data  (bus.Mem_Read_Data),
        .byte_en    (be_gen),
        .write_data (wdata_gen),
        .load_data  (load_ext)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_data_d  = '0;
        mem_req_d    = mem_req_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        write_d      = write_q;
        f3_d         = f3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    write_d = bus.Req_Write;
                    f3_d    = bus.Req_Funct3;
                    off_d   = bus.Req_Address[1:0];
                    if (is_legal(bus.Req_Write, bus.Req_Funct3) &&
                        is_aligned(bus.Req_Funct3, bus.Req_Address[1:0])) begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_write_d = bus.Req_Write;
                        mem_addr_d  = {bus.Req_Address[31:2], 2'b00};
                        mem_be_d    = be_gen;
                        mem_wdata_d = wdata_gen;
                        cnt_d       = '0;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle still completes normally.
                if (bus.Mem_Ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = write_q ? 32'h0 : load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            write_q      <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            write_q      <= write_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.Req_Ready      = ready_q;
    assign bus.Resp_Valid     = resp_valid_q;
    assign bus.Resp_Error     = resp_error_q;
    assign bus.Resp_Data      = resp_data_q;
    assign bus.Mem_Req        = mem_req_q;
    assign bus.Mem_Write      = mem_write_q;
    assign bus.Mem_Address    = mem_addr_q;
    assign bus.Mem_Byte_En    = mem_be_q;
    assign bus.Mem_Write_Data = mem_wdata_q;

endmodule
